// File: rtl/sprite_text_line_if.sv
// Control and font-ROM bus bundle for sprite_text_line: start/busy/done handshake,
// code-point table write port, and the shared font ROM address/data pair.
interface sprite_text_line_if #(
  parameter int CPW   = 7,
  parameter int ADDRW = 11,
  parameter int WIDTH = 16
);
  logic             start;
  logic             busy;
  logic             done;
  logic             cp_we;
  logic [4:0]       cp_idx;
  logic [CPW-1:0]   cp_data;
  logic [ADDRW-1:0] gfx_addr;
  logic [WIDTH-1:0] gfx_data;

  modport master (
    output start, cp_we, cp_idx, cp_data, gfx_data,
    input  busy, done, gfx_addr
  );

  modport slave (
    input  start, cp_we, cp_idx, cp_data, gfx_data,
    output busy, done, gfx_addr
  );
endinterface

// File: rtl/sprite_text_line.sv
// Multi-glyph text sprite: fetches one font row per glyph during the DMA window, then
// draws the scaled string. Optional cursor inversion is enabled by SPRITE_TEXT_CURSOR_EN.
module sprite_text_line #(
  parameter int NCHARS  = 5,
  parameter int WIDTH   = 16,
  parameter int HEIGHT  = 16,
  parameter int SCALE_X = 4,
  parameter int SCALE_Y = 4,
  parameter int LSB     = 0,
  parameter int CPW     = 7,
  parameter int ADDRW   = 11,
  parameter int CORDW   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dma_avail,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sprx,
`ifdef SPRITE_TEXT_CURSOR_EN
  input  logic             cursor_on,
  input  logic [4:0]       cursor_idx,
`endif
  sprite_text_line_if.slave bus,
  output logic             pix
);

  localparam int KW = (NCHARS  > 1) ? $clog2(NCHARS)  : 1;
  localparam int LW = (HEIGHT  > 1) ? $clog2(HEIGHT)  : 1;
  localparam int YW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
  localparam int PW = (WIDTH   > 1) ? $clog2(WIDTH)   : 1;
  localparam int SW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_DMA, S_FETCH, S_WAIT_POS, S_DRAW, S_NEXT_LINE, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [CPW-1:0]   r_cp  [NCHARS];
  logic [WIDTH-1:0] r_row [NCHARS];
  logic [LW-1:0]    r_line;
  logic [YW-1:0]    r_yrep;
  logic [KW-1:0]    r_k;
  logic             r_phase;
  logic [KW-1:0]    r_dg;
  logic [PW-1:0]    r_dp;
  logic [SW-1:0]    r_ds;
  logic             r_last;
  logic             r_pix;

  logic             w_fetch_req;
  logic             w_fetch_cap;
  logic             w_fetch_last;
  logic             w_hit;
  logic             w_emit;
  logic             w_end_pos;
  logic [PW-1:0]    w_bitsel;
  logic             w_ink;
  logic             w_inv;
  logic             w_line_last;
  logic             w_yrep_last;

  // Phase 0 of a glyph needs the bus; phase 1 only latches the ROM output, so a
  // stall can only ever delay the start of the next glyph.
  assign w_fetch_req  = (r_state == S_FETCH) && !r_phase && dma_avail;
  assign w_fetch_cap  = (r_state == S_FETCH) && r_phase;
  assign w_fetch_last = w_fetch_cap && (r_k == KW'(NCHARS - 1));
  assign w_hit        = (r_state == S_WAIT_POS) && (sx == sprx);
  assign w_emit       = w_hit || ((r_state == S_DRAW) && !r_last);
  assign w_end_pos    = (r_dg == KW'(NCHARS - 1)) && (r_dp == PW'(WIDTH - 1)) &&
                        (r_ds == SW'(SCALE_X - 1));
  assign w_bitsel     = (LSB != 0) ? r_dp : (PW'(WIDTH - 1) - r_dp);
  assign w_ink        = r_row[r_dg][w_bitsel];
  assign w_line_last  = (r_line == LW'(HEIGHT - 1));
  assign w_yrep_last  = (r_yrep == YW'(SCALE_Y - 1));

`ifdef SPRITE_TEXT_CURSOR_EN
  assign w_inv = cursor_on && (cursor_idx == 5'(r_dg));
`else
  assign w_inv = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    bus.busy     = (r_state != S_IDLE);
    bus.done     = 1'b0;
    bus.gfx_addr = '0;
    case (r_state)
      S_IDLE:      if (bus.start) w_next = S_START;
      S_START:     w_next = S_WAIT_DMA;
      S_WAIT_DMA:  if (dma_avail) w_next = S_FETCH;
      S_FETCH: begin
        if (w_fetch_req)
          bus.gfx_addr = ADDRW'(32'(r_cp[r_k]) * 32'(HEIGHT) + 32'(r_line));
        if (w_fetch_last) w_next = S_WAIT_POS;
      end
      S_WAIT_POS:  if (w_hit) w_next = S_DRAW;
      S_DRAW:      if (r_last) w_next = S_NEXT_LINE;
      S_NEXT_LINE: begin
        if (!w_yrep_last)     w_next = S_WAIT_DMA;
        else if (w_line_last) w_next = S_DONE;
        else                  w_next = S_WAIT_DMA;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default:     w_next = S_IDLE;
    endcase
  end

  // Code-point table, row buffer and line/glyph bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCHARS; i++) begin
        r_cp[i]  <= '0;
        r_row[i] <= '0;
      end
      r_line  <= '0;
      r_yrep  <= '0;
      r_k     <= '0;
      r_phase <= 1'b0;
    end else begin
      if (bus.cp_we && ({1'b0, bus.cp_idx} < 6'(NCHARS)))
        r_cp[KW'(bus.cp_idx)] <= bus.cp_data;
      case (r_state)
        S_START: begin
          r_line <= '0;
          r_yrep <= '0;
        end
        S_WAIT_DMA: begin
          r_k     <= '0;
          r_phase <= 1'b0;
        end
        S_FETCH: begin
          if (w_fetch_req) begin
            r_phase <= 1'b1;
          end else if (w_fetch_cap) begin
            r_row[r_k] <= bus.gfx_data;
            r_phase    <= 1'b0;
            if (!w_fetch_last) r_k <= r_k + 1'b1;
          end
        end
        S_NEXT_LINE: begin
          if (!w_yrep_last) begin
            r_yrep <= r_yrep + 1'b1;
          end else if (!w_line_last) begin
            r_yrep <= '0;
            r_line <= r_line + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel walker: the first pixel is registered in the cycle sx==sprx so column
  // sprx+i appears on pix while sx==sprx+i+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dg   <= '0;
      r_dp   <= '0;
      r_ds   <= '0;
      r_last <= 1'b0;
      r_pix  <= 1'b0;
    end else if (w_emit) begin
      r_pix <= w_ink ^ w_inv;
      if (w_end_pos) r_last <= 1'b1;
      if (r_ds == SW'(SCALE_X - 1)) begin
        r_ds <= '0;
        if (r_dp == PW'(WIDTH - 1)) begin
          r_dp <= '0;
          r_dg <= r_dg + 1'b1;
        end else begin
          r_dp <= r_dp + 1'b1;
        end
      end else begin
        r_ds <= r_ds + 1'b1;
      end
    end else begin
      r_pix <= 1'b0;
      if (r_state != S_DRAW) begin
        r_dg   <= '0;
        r_dp   <= '0;
        r_ds   <= '0;
        r_last <= 1'b0;
      end
    end
  end

  assign pix = r_pix;

endmodule
